// File: rtl/spi_rx_deser_pkg.sv
// Shared constants for the SPI receive deserializer: word size, synchronizer depth
// and the bit layout of the synchronized {from_device, sclk_n, cs_n} bundle.
package spi_rx_deser_pkg;

    localparam int PKG_SIZE_DEF    = 16;
    localparam int SYNC_STAGES_DEF = 2;

    localparam int SYNC_W   = 3;
    localparam int DIN_BIT  = 2;
    localparam int SCLK_BIT = 1;
    localparam int CS_BIT   = 0;

    // Serial clock and chip select idle high; data idles low.
    localparam logic [SYNC_W-1:0] SYNC_RST = 3'b011;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_rx_deser_sync_pipe.sv
// Reset-clearable flop chain with a per-bit reset value; used to synchronize and
// equally delay the serial inputs.
module sync_pipe #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // its neighbour's pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= {STAGES{RST_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/spi_rx_deser.sv
// Receive-side SPI deserializer: samples from_device on sclk_n falling edges inside a
// cs_n-low frame, assembles MSB-first words and offers them on a valid/ready register.
module spi_rx_deser
    import spi_rx_deser_pkg::*;
#(
    parameter int PKG_SIZE    = PKG_SIZE_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk_n,
    input  logic                cs_n,
    input  logic                from_device,
    output logic [PKG_SIZE-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                overrun,
    output logic                frame_err
);

    localparam int CNT_W = cnt_width(PKG_SIZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_CS = 2'd2
    } state_e;

    logic [SYNC_W-1:0] sync_out;
    logic              din_s, sclk_s, cs_s, smp;

    sync_pipe #(
        .WIDTH  (SYNC_W),
        .STAGES (SYNC_STAGES),
        .RST_VAL(SYNC_RST)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  ({from_device, sclk_n, cs_n}),
        .q  (sync_out)
    );

    assign din_s  = sync_out[DIN_BIT];
    assign sclk_s = sync_out[SCLK_BIT];
    assign cs_s   = sync_out[CS_BIT];

    // The shift register keeps only the first PKG_SIZE-1 bits; the final bit is taken
    // straight from din_s when the word completes.
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [PKG_SIZE-2:0] shreg_q, shreg_d;
    logic [PKG_SIZE-1:0] rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                overrun_q, overrun_d;
    logic                frame_err_q, frame_err_d;
    logic                sclk_p_q;

    assign smp = sclk_p_q & ~sclk_s & ~cs_s;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!cs_s) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (cs_s) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (smp) begin
                    shreg_d   = {shreg_q[PKG_SIZE-3:0], din_s};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(PKG_SIZE - 1)) begin
                        state_d = WAIT_CS;
                        if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = {shreg_q, din_s};
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
            WAIT_CS: begin
                if (cs_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the whole datapath is reset, including the shift register, so a frame
    // interrupted by rst leaves no stale bits behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            sclk_p_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            sclk_p_q    <= sclk_s;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_rx_deser.sv
// Scoreboard bench for spi_rx_deser: expected words are queued as frames are sent and
// compared when the consumer accepts them; error pulses are counted against expectations.
module tb_spi_rx_deser;

    localparam int P = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sclk_n = 1'b1;
    logic         cs_n = 1'b1;
    logic         from_device = 1'b0;
    logic [P-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready = 1'b0;
    logic         overrun;
    logic         frame_err;

    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           last_fall = 0;
    int           valid_rise_cyc = -1;
    int           n_rises = 0;
    int           n_overrun = 0;
    int           n_frame_err = 0;
    logic         prev_valid = 1'b0;
    logic [P-1:0] exp_q[$];

    spi_rx_deser #(.PKG_SIZE(P), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk_n     (sclk_n),
        .cs_n       (cs_n),
        .from_device(from_device),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: accepted words are popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && !prev_valid) begin
                n_rises++;
                valid_rise_cyc = cyc;
            end
            if (overrun) n_overrun++;
            if (frame_err) n_frame_err++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {16'h0, rx_data}, 32'hDEAD_0000);
                end else begin
                    check("word", {16'h0, rx_data}, {16'h0, exp_q.pop_front()});
                end
            end
        end
        prev_valid = rx_valid;
    end

    task automatic send_frame(input logic [P-1:0] data, input int nbits,
                              input bit push, input bit ready_pulse);
        if (push) exp_q.push_back(data);
        cs_n = 1'b0;
        tick(2);
        for (int i = 0; i < nbits; i++) begin
            from_device = (i < P) ? data[P-1-i] : i[0];
            tick(4);
            sclk_n    = 1'b0;
            last_fall = cyc;
            if (ready_pulse && i == nbits - 1) begin
                tick(2);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
                check("t5_valid_kept", {31'h0, rx_valid}, 32'h1);
                check("t5_data", {16'h0, rx_data}, 32'h5555);
                tick(1);
            end else begin
                tick(4);
            end
            sclk_n = 1'b1;
        end
        tick(2);
        cs_n = 1'b1;
        tick(8);
    endtask

    task automatic drain();
        int budget;
        budget   = 200;
        rx_ready = 1'b1;
        while (exp_q.size() != 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        tick(2);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int rises0, ov0, fe0;

        tick(3);
        check("rst_valid", {31'h0, rx_valid}, 0);
        check("rst_data", {16'h0, rx_data}, 0);
        check("rst_pulses", {30'h0, overrun, frame_err}, 0);
        rst = 1'b0;
        tick(4);

        // 1: single frame with consumer ready, latency from last sclk_n fall
        rx_ready = 1'b1;
        rises0   = n_rises;
        send_frame(16'hA5C3, P, 1'b1, 1'b0);
        check("t1_rises", n_rises - rises0, 1);
        check("t1_latency", valid_rise_cyc - last_fall, 3);
        check("t1_queue", exp_q.size(), 0);

        // 2: overrun while holding register full
        rx_ready = 1'b0;
        ov0      = n_overrun;
        send_frame(16'h1234, P, 1'b1, 1'b0);
        send_frame(16'hBEEF, P, 1'b0, 1'b0);
        check("t2_overrun", n_overrun - ov0, 1);
        check("t2_hold_data", {16'h0, rx_data}, 32'h1234);
        check("t2_hold_valid", {31'h0, rx_valid}, 1);
        drain();
        check("t2_valid_clr", {31'h0, rx_valid}, 0);

        // 3: short frame, then a clean one
        fe0    = n_frame_err;
        rises0 = n_rises;
        send_frame(16'hFFFF, 7, 1'b0, 1'b0);
        check("t3_frame_err", n_frame_err - fe0, 1);
        check("t3_no_valid", n_rises - rises0, 0);
        send_frame(16'h00FF, P, 1'b1, 1'b0);
        drain();

        // 4: reset mid-frame abandons the partial word
        fe0  = n_frame_err;
        cs_n = 1'b0;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            from_device = i[0];
            tick(4);
            sclk_n = 1'b0;
            tick(4);
            sclk_n = 1'b1;
        end
        rst  = 1'b1;
        cs_n = 1'b1;
        tick(1);
        check("t4_rst_out", {rx_data, 13'h0, rx_valid, overrun, frame_err}, 0);
        rst = 1'b0;
        tick(6);
        send_frame(16'h8001, P, 1'b1, 1'b0);
        drain();
        check("t4_no_frame_err", n_frame_err - fe0, 0);

        // 5: accept on the exact cycle the next word completes
        rx_ready = 1'b0;
        ov0      = n_overrun;
        send_frame(16'hAAAA, P, 1'b1, 1'b0);
        send_frame(16'h5555, P, 1'b1, 1'b1);
        check("t5_no_overrun", n_overrun - ov0, 0);
        drain();

        // 6: extra edges after a complete word are ignored
        fe0    = n_frame_err;
        rises0 = n_rises;
        send_frame(16'hF00F, 18, 1'b1, 1'b0);
        drain();
        check("t6_rises", n_rises - rises0, 1);
        check("t6_no_frame_err", n_frame_err - fe0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
